// File: rtl/decryption_if.sv
// Ciphertext-in / plaintext-out byte handshake bundle for the decryption stage.
// Latency: n/a (wires only). Backpressure: in_ready / out_ready carry the stall in each direction.
// Ports: in_valid/in_ready/datain (ciphertext side), out_valid/out_ready/dataout (plaintext side).
interface decryption_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] datain;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dataout;

    // master: the environment around the block (drives ciphertext, consumes plaintext)
    modport master (
        output in_valid, datain, out_ready,
        input  in_ready, out_valid, dataout
    );

    // slave: the decryption block itself
    modport slave (
        input  in_valid, datain, out_ready,
        output in_ready, out_valid, dataout
    );
endinterface

// File: rtl/decryption.sv
// Receive-side keystream stage: regenerates a 64-bit LFSR keystream and XORs it onto ciphertext bytes.
// Latency: 1 cycle accept-to-output; minimum 6 cycles per byte (5 warm-up steps + 1 accept step).
// Backpressure: warm-up runs regardless; the accept waits until the output register is free or draining.
//
// Ports: clk, rst (sync, active-high), seed/load (restart keystream), bus (decryption_if.slave),
//        byte_count (16-bit delivered-byte counter, present only when DECRYPTION_BYTECNT_EN is defined).
// Optional feature macro: DECRYPTION_BYTECNT_EN.
module decryption (
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        seed,
    input  logic               load,
    decryption_if.slave        bus
`ifdef DECRYPTION_BYTECNT_EN
    ,
    output logic [15:0]        byte_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] s_q, s_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  dataout_q, dataout_d;
    logic        out_valid_q, out_valid_d;

    logic        fb;
    logic [63:0] s_step;
    logic [7:0]  ks;
    logic        in_ready;
    logic        accept;
    logic        drain;

    // Feedback and keystream byte both come from the current (pre-step) state.
    assign fb     = s_q[4] ^ s_q[3] ^ s_q[1] ^ s_q[0];
    assign s_step = {fb, s_q[63:1]};
    assign ks     = {2'b00, fb, s_q[63:59]};

    assign in_ready = (state_q == ARMED) && (!out_valid_q || bus.out_ready);
    // A load cycle swallows in_valid even if in_ready happens to be high.
    assign accept   = bus.in_valid && in_ready && !load;
    assign drain    = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.dataout   = dataout_q;

`ifdef DECRYPTION_BYTECNT_EN
    logic [15:0] byte_count_q, byte_count_d;
    assign byte_count = byte_count_q;
`endif

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        dataout_d   = dataout_q;
        out_valid_d = out_valid_q;
`ifdef DECRYPTION_BYTECNT_EN
        byte_count_d = byte_count_q;
`endif
        if (load) begin
            s_d         = seed;
            cnt_d       = 3'd0;
            state_d     = WARM;
            out_valid_d = 1'b0;
`ifdef DECRYPTION_BYTECNT_EN
            byte_count_d = 16'd0;
`endif
        end else begin
            if (drain) begin
                out_valid_d = 1'b0;
`ifdef DECRYPTION_BYTECNT_EN
                byte_count_d = byte_count_q + 16'd1;
`endif
            end
            case (state_q)
                WARM: begin
                    s_d = s_step;
                    if (cnt_q == 3'd4) begin
                        cnt_d   = 3'd0;
                        state_d = ARMED;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ARMED: begin
                    if (accept) begin
                        // New byte overrides a same-cycle drain, so out_valid stays high.
                        dataout_d   = bus.datain ^ ks;
                        out_valid_d = 1'b1;
                        s_d         = s_step;
                        cnt_d       = 3'd0;
                        state_d     = WARM;
                    end
                end
                default: begin
                    // IDLE: nothing loaded, LFSR holds.
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= 64'd0;
            cnt_q       <= 3'd0;
            dataout_q   <= 8'd0;
            out_valid_q <= 1'b0;
`ifdef DECRYPTION_BYTECNT_EN
            byte_count_q <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            dataout_q   <= dataout_d;
            out_valid_q <= out_valid_d;
`ifdef DECRYPTION_BYTECNT_EN
            byte_count_q <= byte_count_d;
`endif
        end
    end

endmodule

// File: doc/decryption.md
# decryption

Receive-side keystream stage that sits directly downstream of the encryption stage. It accepts ciphertext bytes over a valid/ready handshake and regenerates the same 64-bit LFSR keystream from a shared seed. Each byte is XORed with its keystream byte, and the recovered plaintext is presented on a registered valid/ready output. LFSR cadence is 6 steps per byte, so bytes pair one-to-one with the encryptor's output bytes after a common `load`.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `seed`  in  64  LFSR seed, sampled when `load`=1
- `load`  in  1  restart keystream from `seed`
- `in_valid`  in  1  ciphertext byte present on `datain`
- `in_ready`  out  1  block can accept a byte this cycle
- `datain`  in  8  ciphertext byte
- `out_valid`  out  1  `dataout` holds a plaintext byte
- `out_ready`  in  1  consumer takes `dataout` this cycle
- `dataout`  out  8  plaintext byte
- `byte_count`  out  16  bytes delivered since load (only with `DECRYPTION_BYTECNT_EN`)

## Operation
- **LFSR step:**
  - `f = s[4]^s[3]^s[1]^s[0]`
  - `s <= {f, s[63:1]}`
- **Keystream byte:** `K = {2'b00, f, s[63:59]}`, computed from the current state.
- **State machine states:**
  - **IDLE:** no seed loaded; LFSR holds; `in_ready`=0.
  - **WARM:** LFSR steps every cycle while a 3-bit step counter counts 0..4. The step at count 4 moves the FSM to ARMED, so 5 steps are taken in total.
  - **ARMED:** LFSR holds. `in_ready = !out_valid || out_ready`.
    - On an accept (`in_valid && in_ready`):
      - `dataout <= datain ^ K`
      - `out_valid <= 1`
      - LFSR takes one step (the 6th)
      - step counter is cleared and the FSM returns to WARM.
- **Output register:** `out_valid` clears on `out_valid && out_ready` unless a new accept happens in the same cycle. A simultaneous drain and accept keeps `out_valid`=1 and loads the new byte.
- **Priority:** `rst` > `load` > accept.
  - **`load`:** from any state, sets `s<=seed`, step counter 0, FSM=WARM, `out_valid`=0, `byte_count`=0. Any pending output byte is discarded. `in_valid` is ignored in a load cycle.
- **Reset values:** `s`=0, FSM=IDLE, step counter 0, `in_ready`=0, `out_valid`=0, `dataout`=0, `byte_count`=0. Reset mid-byte discards everything.
- **Seed of 0:** the LFSR stays 0 and K=0, so the block is a pass-through. This is legal and is not flagged.
- **While `out_valid`=0:** `dataout` holds its last value.

## Timing
- **Load to first byte:** `load` at edge E0 → WARM steps at E1..E5 → `in_ready`=1 in the cycle after E5, provided the output slot is free.
- **Accept to output:** accept at edge En → `out_valid`=1 from En, visible in the next cycle (1-cycle latency).
- **Throughput:** minimum 6 cycles per byte (5 WARM + 1 ARMED accept), matching the encryptor cadence.
- **Warm-up under backpressure:** WARM proceeds while the output is stalled. Only the ARMED accept waits on `out_ready`.
- **Handshake rules:**
  - `in_ready` is combinational from FSM state, `out_valid` and `out_ready`.
  - `dataout` and `out_valid` are registered.
  - `dataout` is stable while `out_valid && !out_ready`.

## Configuration
- **`DECRYPTION_BYTECNT_EN` defined:**
  - `byte_count` port exists.
  - Increments by 1 on each output handshake (`out_valid && out_ready`), wrapping 0xFFFF→0x0000.
  - Cleared by `rst` and `load`.
- **Not defined:** the port and counter are absent. All other behaviour is identical.

## Test plan
- **Reset:** `rst`=1 for 2 cycles, then idle with no `load` → `in_ready`=0, `out_valid`=0, `dataout`=0 indefinitely, even with `in_valid`=1.
- **Seed 1, two bytes:** `seed=64'h1`, pulse `load`, `out_ready`=1.
  - `in_ready` first rises 5 cycles after `load`.
  - First byte: `datain`=0xA5 → `dataout`=0xA4 (K=0x01).
  - Next accept is 6 cycles after the first: `datain`=0x3C → `dataout`=0x3C (K=0x00).
- **Zero seed:** seed 0, bytes 0x00, 0xFF, 0x5A → outputs 0x00, 0xFF, 0x5A, spaced 6 cycles apart.
- **Backpressure:** seed 1, `out_ready`=0, first byte accepted.
  - `out_valid` holds 0xA4.
  - After the 5 WARM cycles, `in_ready`=0 while `in_valid`=1.
  - Raise `out_ready` → same-cycle drain and accept of the second byte; `out_valid` stays 1.
- **Load mid-stream:** `out_valid`=1 pending, assert `load` with `seed=64'h1` and `in_valid`=1 → `out_valid`=0 next cycle, no byte accepted, first byte after 5 WARM cycles decrypts with K=0x01.
- **Byte counter (`DECRYPTION_BYTECNT_EN`):** deliver 3 bytes → `byte_count`=3; `load` → 0; force the count to 0xFFFF and deliver one byte → 0x0000.
